// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, issues single-outstanding reads, and feeds the decoder via an output register plus a one-entry skid.
// Define FETCH_ALIGN_CHECK_EN to flag misaligned redirect targets and halt fetch; otherwise they are silently word-aligned.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        inst_valid,
  output logic        fetch_fault
);

  typedef enum logic [1:0] {ST_REQ, ST_WAIT, ST_DRAIN, ST_FULL} state_t;

  state_t      state, state_nxt;
  logic [31:0] fetch_pc, fetch_pc_nxt;
  logic [31:0] skid_inst, skid_inst_nxt;
  logic [31:0] skid_pc, skid_pc_nxt;
  logic        skid_valid, skid_valid_nxt;
  logic [31:0] instruction_nxt, pc_nxt;
  logic        inst_valid_nxt;
  logic        consume, rsp_accept, halted;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fault_q;

  // Sticky fault; once set, no further requests are issued until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      fault_q <= 1'b0;
    else if (redirect && (redirect_pc[1:0] != 2'b00))
      fault_q <= 1'b1;
  end

  assign halted      = fault_q;
  assign fetch_fault = fault_q;
`else
  assign halted      = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  assign consume    = inst_valid && !stall;
  assign rsp_accept = (state == ST_WAIT) && imem_rvalid;
  assign imem_addr  = fetch_pc;
  assign pc_plus4   = pc + 32'd4;

  always_comb begin
    state_nxt       = state;
    fetch_pc_nxt    = fetch_pc;
    instruction_nxt = instruction;
    pc_nxt          = pc;
    inst_valid_nxt  = inst_valid;
    skid_inst_nxt   = skid_inst;
    skid_pc_nxt     = skid_pc;
    skid_valid_nxt  = skid_valid;
    imem_req        = (state == ST_REQ) && !halted;

    // Skid drains first so program order is kept; a fresh word only bypasses when the skid is empty.
    if (consume && skid_valid) begin
      instruction_nxt = skid_inst;
      pc_nxt          = skid_pc;
      inst_valid_nxt  = 1'b1;
      skid_valid_nxt  = 1'b0;
    end else if (consume || !inst_valid) begin
      if (rsp_accept) begin
        instruction_nxt = imem_rdata;
        pc_nxt          = fetch_pc;
        inst_valid_nxt  = 1'b1;
      end else begin
        instruction_nxt = NOP_INST;
        inst_valid_nxt  = 1'b0;
      end
    end else if (rsp_accept) begin
      skid_inst_nxt  = imem_rdata;
      skid_pc_nxt    = fetch_pc;
      skid_valid_nxt = 1'b1;
    end

    if (rsp_accept)
      fetch_pc_nxt = fetch_pc + 32'd4;

    case (state)
      ST_REQ:   if (imem_req && imem_ready) state_nxt = ST_WAIT;
      ST_WAIT:  if (imem_rvalid) state_nxt = skid_valid_nxt ? ST_FULL : ST_REQ;
      ST_FULL:  if (!skid_valid_nxt) state_nxt = ST_REQ;
      ST_DRAIN: if (imem_rvalid) state_nxt = ST_REQ;
      default:  state_nxt = ST_REQ;
    endcase

    // A response still in flight at redirect time must be swallowed in DRAIN.
    if (redirect) begin
      inst_valid_nxt  = 1'b0;
      instruction_nxt = NOP_INST;
      skid_valid_nxt  = 1'b0;
      fetch_pc_nxt    = redirect_pc & 32'hFFFF_FFFC;
      if (((state == ST_WAIT) || (state == ST_DRAIN)) && !imem_rvalid)
        state_nxt = ST_DRAIN;
      else if ((state == ST_REQ) && imem_req && imem_ready)
        state_nxt = ST_DRAIN;
      else
        state_nxt = ST_REQ;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_REQ;
      fetch_pc    <= RESET_PC;
      instruction <= NOP_INST;
      pc          <= 32'h0;
      inst_valid  <= 1'b0;
      skid_inst   <= 32'h0;
      skid_pc     <= 32'h0;
      skid_valid  <= 1'b0;
    end else begin
      state       <= state_nxt;
      fetch_pc    <= fetch_pc_nxt;
      instruction <= instruction_nxt;
      pc          <= pc_nxt;
      inst_valid  <= inst_valid_nxt;
      skid_inst   <= skid_inst_nxt;
      skid_pc     <= skid_pc_nxt;
      skid_valid  <= skid_valid_nxt;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios, then randomized traffic checked against a program-order scoreboard.
// Reacts to FETCH_ALIGN_CHECK_EN the same way the design does.
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC_TB = 32'h0000_0000;
  localparam logic [31:0] NOP         = 32'h0000_0013;

  logic        clk, rst, stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ready, imem_rvalid;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] instruction, pc, pc_plus4;
  logic        inst_valid, fetch_fault;

  int          vectors, miscompares, consumed;
  logic [31:0] exp_q[$];
  logic [31:0] exp_tail;
  bit          stream_on;
  bit          ready_rand;
  int          lat_min, lat_max;

  instruction_fetch #(.RESET_PC(RESET_PC_TB), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .instruction(instruction), .pc(pc), .pc_plus4(pc_plus4),
    .inst_valid(inst_valid), .fetch_fault(fetch_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      default: return {addr[15:0] ^ 16'h5A3C, addr[31:16]} ^ 32'h1357_9BDF;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  task automatic expectStream(input logic [31:0] start);
    exp_q.delete();
    for (int i = 0; i < 4; i++)
      exp_q.push_back(start + 32'(4 * i));
    exp_tail  = start + 32'd12;
    stream_on = 1'b1;
  endtask

  task automatic applyStimulus(input logic s, input logic r, input logic [31:0] rpc);
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    if (r) begin
`ifdef FETCH_ALIGN_CHECK_EN
      if (rpc[1:0] != 2'b00) begin
        exp_q.delete();
        stream_on = 1'b0;
      end else
        expectStream(rpc);
`else
      expectStream({rpc[31:2], 2'b00});
`endif
    end
  endtask

  // Memory model: accepts when req and ready meet, answers after a random latency, and polices the handshake.
  initial begin : memory_model
    logic        pend, hold_chk;
    logic [31:0] pend_addr, hold_addr;
    int          lat_cnt;
    pend = 1'b0; hold_chk = 1'b0; pend_addr = '0; hold_addr = '0; lat_cnt = 0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    forever begin
      @(negedge clk); #1;
      if (rst) begin
        pend = 1'b0; hold_chk = 1'b0; imem_rvalid = 1'b0; imem_ready = 1'b0;
      end else begin
        imem_rvalid = 1'b0;
        if (pend) begin
          if (lat_cnt <= 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend_addr);
            pend        = 1'b0;
          end else
            lat_cnt--;
        end
        if (hold_chk) begin
          checkOutput("imem_req_held", {31'b0, imem_req}, 32'd1);
          checkOutput("imem_addr_held", imem_addr, hold_addr);
        end
        imem_ready = ready_rand ? ($urandom_range(1, 0) == 1) : 1'b1;
        if (imem_req) begin
          checkOutput("imem_single_outstanding", {31'b0, pend}, 32'd0);
          checkOutput("imem_addr_aligned", {30'b0, imem_addr[1:0]}, 32'd0);
          if (imem_ready) begin
            pend      = 1'b1;
            pend_addr = imem_addr;
            lat_cnt   = int'($urandom_range(lat_max, lat_min));
          end
        end
        hold_chk  = imem_req && !imem_ready && !redirect;
        hold_addr = imem_addr;
      end
    end
  end

  // Scoreboard monitor: every consumed instruction must be the next one in program order.
  initial begin : scoreboard_monitor
    logic [31:0] exp_pc;
    forever begin
      @(negedge clk); #2;
      if (!rst && !redirect) begin
        if (inst_valid && !stall) begin
          consumed++;
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL scoreboard_empty at %0t: got pc %h, expected no instruction", $time, pc);
          end else begin
            exp_pc = exp_q.pop_front();
            if (stream_on) begin
              exp_tail = exp_tail + 32'd4;
              exp_q.push_back(exp_tail);
            end
            checkOutput("sb_pc", pc, exp_pc);
            checkOutput("sb_instruction", instruction, mem_word(exp_pc));
            checkOutput("sb_pc_plus4", pc_plus4, exp_pc + 32'd4);
          end
        end
        if (!inst_valid)
          checkOutput("nop_when_invalid", instruction, NOP);
`ifndef FETCH_ALIGN_CHECK_EN
        checkOutput("fetch_fault_tied_low", {31'b0, fetch_fault}, 32'd0);
`endif
      end
    end
  end

  initial begin : stimulus
    int          budget, cnt, base;
    logic [31:0] tgt;
    logic        s, r;
    vectors = 0; miscompares = 0; consumed = 0;
    stream_on = 1'b0; exp_tail = '0;
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    ready_rand = 1'b0; lat_min = 1; lat_max = 1;

    repeat (3) @(negedge clk);
    checkOutput("reset_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("reset_instruction", instruction, NOP);
    checkOutput("reset_pc", pc, 32'h0);
    checkOutput("reset_fetch_fault", {31'b0, fetch_fault}, 32'd0);
    expectStream(RESET_PC_TB);
    rst = 1'b0;
    checkOutput("first_req", {31'b0, imem_req}, 32'd1);
    checkOutput("first_req_addr", imem_addr, RESET_PC_TB);

    budget = 0;
    do begin @(negedge clk); budget++; end while (!inst_valid && budget < 20);
    checkOutput("first_valid_seen", {31'b0, inst_valid}, 32'd1);
    checkOutput("first_valid_pc", pc, 32'h0);
    checkOutput("first_valid_inst", instruction, 32'h0050_0093);
    checkOutput("first_pc_plus4", pc_plus4, 32'h4);
    @(negedge clk);
    checkOutput("bubble_inst_valid", {31'b0, inst_valid}, 32'd0);
    @(negedge clk);
    checkOutput("second_valid", {31'b0, inst_valid}, 32'd1);
    checkOutput("second_pc", pc, 32'h4);
    checkOutput("second_inst", instruction, 32'h00A0_0113);
    checkOutput("second_pc_plus4", pc_plus4, 32'h8);

    // Stall long enough for PC 8 to land in the skid.
    applyStimulus(1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput("stall_hold_valid", {31'b0, inst_valid}, 32'd1);
      checkOutput("stall_hold_pc", pc, 32'h4);
      if (i > 0) checkOutput("stall_no_req", {31'b0, imem_req}, 32'd0);
    end
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0);
    @(negedge clk);
    checkOutput("skid_valid", {31'b0, inst_valid}, 32'd1);
    checkOutput("skid_pc", pc, 32'h8);
    checkOutput("skid_inst", instruction, mem_word(32'h8));
    checkOutput("after_skid_req", {31'b0, imem_req}, 32'd1);
    checkOutput("after_skid_addr", imem_addr, 32'hC);

    // Redirect while a slow response is still outstanding.
    lat_min = 3; lat_max = 3;
    @(negedge clk);
    checkOutput("wait_no_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(1'b0, 1'b1, 32'h100);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("redir_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("redir_nop", instruction, NOP);
    budget = 0;
    while (!imem_req && budget < 20) begin
      checkOutput("drain_no_valid", {31'b0, inst_valid}, 32'd0);
      @(negedge clk);
      budget++;
    end
    checkOutput("redir_req_seen", {31'b0, imem_req}, 32'd1);
    checkOutput("redir_req_addr", imem_addr, 32'h100);

    // Redirect under stall with the skid occupied.
    lat_min = 1; lat_max = 1;
    budget = 0;
    while (!inst_valid && budget < 20) begin @(negedge clk); budget++; end
    checkOutput("redir_target_pc", pc, 32'h100);
    applyStimulus(1'b1, 1'b0, 32'h0);
    repeat (4) @(negedge clk);
    checkOutput("full_hold_pc", pc, 32'h100);
    checkOutput("full_no_req", {31'b0, imem_req}, 32'd0);
    applyStimulus(1'b1, 1'b1, 32'h40);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0);
    checkOutput("flush_inst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("flush_nop", instruction, NOP);
    checkOutput("flush_req", {31'b0, imem_req}, 32'd1);
    checkOutput("flush_req_addr", imem_addr, 32'h40);

    // Wrap across the top of the address space, then measure steady-state throughput.
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFF8);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0);
    budget = 0;
    while (!(inst_valid && pc == 32'hFFFF_FFFC) && budget < 40) begin @(negedge clk); budget++; end
    checkOutput("wrap_pc", pc, 32'hFFFF_FFFC);
    checkOutput("wrap_pc_plus4", pc_plus4, 32'h0);
    checkOutput("wrap_req", {31'b0, imem_req}, 32'd1);
    checkOutput("wrap_req_addr", imem_addr, 32'h0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (inst_valid) cnt++;
      @(negedge clk);
    end
    checkOutput("throughput_2cyc", 32'(cnt), 32'd5);

    applyStimulus(1'b0, 1'b1, 32'h102);
    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("fault_set", {31'b0, fetch_fault}, 32'd1);
    for (int i = 0; i < 12; i++) begin
      checkOutput("halt_no_req", {31'b0, imem_req}, 32'd0);
      checkOutput("halt_no_valid", {31'b0, inst_valid}, 32'd0);
      @(negedge clk);
    end
`else
    checkOutput("no_fault", {31'b0, fetch_fault}, 32'd0);
    budget = 0;
    while (!imem_req && budget < 20) begin @(negedge clk); budget++; end
    checkOutput("misaligned_req_seen", {31'b0, imem_req}, 32'd1);
    checkOutput("misaligned_req_addr", imem_addr, 32'h100);
`endif

    // Randomized traffic with a mid-run reset.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    expectStream(RESET_PC_TB);
    rst = 1'b0;
    ready_rand = 1'b1; lat_min = 1; lat_max = 3;
    base = consumed;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 1500) begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0);
      end else if (i == 1502) begin
        expectStream(RESET_PC_TB);
        rst = 1'b0;
      end else if (!rst) begin
        s = ($urandom_range(9, 0) < 3);
        r = ($urandom_range(31, 0) == 0);
        if ($urandom_range(7, 0) == 0)
          tgt = 32'hFFFF_FFF0 + 32'($urandom_range(15, 0));
        else
          tgt = $urandom;
`ifdef FETCH_ALIGN_CHECK_EN
        tgt[1:0] = 2'b00;
`endif
        applyStimulus(s, r, tgt);
      end
    end
    checkOutput("random_progress", {31'b0, (consumed - base) > 100}, 32'd1);

    @(negedge clk);
    applyStimulus(1'b0, 1'b0, 32'h0);
    ready_rand = 1'b0;
    base = consumed;
    repeat (30) @(negedge clk);
    checkOutput("final_progress", {31'b0, (consumed - base) >= 5}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction fetch stage directly upstream of the decoder: owns the fetch program counter, issues single-outstanding word reads to instruction memory, and presents one instruction with its PC to the decoder. It takes a redirect from the execute stage for taken branches and jumps, and it holds or skids the fetched word while the decoder stalls. While no valid instruction is held, it drives a NOP (`32'h0000_0013`) so the decoder never sees stale opcodes.

## Interface
Parameters:
- `RESET_PC`, default `32'h0000_0000`: first fetch address after reset.
- `NOP_INST`, default `32'h0000_0013`: value driven on `instruction` when not valid.

Ports:
- Clocking: one clock; reset is asynchronous and active-high.
- `clk` in 1: rising-edge clock.
- `rst` in 1: asynchronous, active-high reset.
- `stall` in 1: decoder cannot accept; hold current output.
- `redirect` in 1: taken branch or jump from execute.
- `redirect_pc` in 32: redirect target.
- `imem_req` out 1: read request valid.
- `imem_addr` out 32: byte address of the request; always word-aligned.
- `imem_ready` in 1: memory accepts the request this cycle.
- `imem_rvalid` in 1: single-cycle pulse; read data is valid.
- `imem_rdata` in 32: read data.
- `instruction` out 32: instruction to the decoder.
- `pc` out 32: address of `instruction`.
- `pc_plus4` out 32: `pc + 4`, modulo 2^32. Combinational, for the link value.
- `inst_valid` out 1: `instruction` and `pc` are valid.
- `fetch_fault` out 1: misaligned redirect seen. Present only with the macro enabled; otherwise tied 0.

## Operation
Internal state:
- `fetch_pc`.
- Output register: `instruction`, `pc`, `inst_valid`.
- One-entry skid buffer: `skid_inst`, `skid_pc`, `skid_valid`.
- FSM with states REQ, WAIT, DRAIN, FULL.

Consume and transfer rules:
- Consume: the output is taken when `inst_valid && !stall`.
- Output register update on consume, in priority order:
  1. If skid is valid, load the skid entry.
  2. Else, on an accepted (non-killed) `imem_rvalid` in the same cycle, load the fetched word.
  3. Else, clear `inst_valid`.
- Fetched word with the output register free: it goes directly to the output register.
- Fetched word with the output register occupied and not consumed: it goes to the skid buffer.
- PC bookkeeping: the captured PC is `fetch_pc`, and `fetch_pc` advances by 4 on every accepted response.

FSM:
- REQ:
  - `imem_req=1`, `imem_addr=fetch_pc`.
  - `imem_ready` high → WAIT.
- WAIT:
  - `imem_req=0`.
  - `imem_rvalid` high: capture as above.
  - Next state is FULL if the skid becomes valid, else REQ.
- FULL:
  - No requests.
  - When the skid drains into the output register → REQ.
- DRAIN:
  - A killed response is outstanding; `imem_req=0`.
  - `imem_rvalid` high: discard the data → REQ.

Redirect (highest priority, overrides `stall`):
- Next cycle: `inst_valid=0`, `instruction=NOP_INST`, `skid_valid=0`, `fetch_pc=redirect_pc` with bits [1:0] handled per Configuration.
- Next state depends on the state at redirect:
  - WAIT with no `imem_rvalid` this cycle → DRAIN.
  - REQ with `imem_ready` high this cycle → DRAIN.
  - Otherwise → REQ.
- Redirect while in DRAIN: update `fetch_pc`, stay in DRAIN.

Arithmetic: all PC arithmetic is 32-bit and wraps; `32'hFFFF_FFFC + 4 = 0`.

## Timing
Reset values:
- `fetch_pc=RESET_PC`, state REQ.
- `inst_valid=0`, `instruction=NOP_INST`, `pc=0`, `skid_valid=0`, `fetch_fault=0`.
- `imem_req=1` from the first cycle with `rst` low.
- Asserting `rst` mid-transaction aborts the transaction immediately. Any later `imem_rvalid` must be absent: the memory shares `rst`.

Latency and throughput:
- Latency: `inst_valid` rises the cycle after `imem_rvalid`.
- Best case, with `imem_ready=1` and 1-cycle `imem_rvalid`: one instruction every 2 cycles.

Handshake rules:
- At most one request is outstanding.
- `imem_addr` is stable while `imem_req` is high and `imem_ready` is low.
- `imem_req` must not drop without acceptance, except on redirect or reset.

Output behaviour:
- `instruction` and `pc` are registered and hold steady while `stall` is high.
- `pc_plus4` follows `pc` combinationally.

## Configuration
`FETCH_ALIGN_CHECK_EN`:
- Defined: a redirect with `redirect_pc[1:0]!=0` sets `fetch_fault` (sticky until reset), flushes as a normal redirect, and enters a halted condition: no further requests, `inst_valid` stays 0.
- Undefined: `redirect_pc[1:0]` is forced to `00`, fetch continues, and `fetch_fault` is constant 0.

## Test plan
- Reset release with `RESET_PC=0`, `imem_ready=1`, 1-cycle `rvalid`, data `0x00500093`, `0x00A00113` → outputs `pc=0`, `instruction=0x00500093`, then `pc=4`, `instruction=0x00A00113`; `inst_valid` for one cycle every 2 cycles; `pc_plus4=4`, then 8.
- `stall` held 6 cycles while the response for PC 8 arrives → the output holds PC 4, PC 8 goes to the skid, and no `imem_req` is issued. After release: PC 4 is consumed, then PC 8 is presented the next cycle, then a request for 12 is issued.
- `redirect` to `0x100` in WAIT, before `rvalid` → the next `rvalid` data is discarded, the next request is `imem_addr=0x100`, and `inst_valid` stays 0 until the `0x100` response.
- `redirect` to `0x40` with `stall=1` and the skid full → `inst_valid=0`, `instruction=0x00000013` next cycle, skid cleared, and a request for `0x40` is issued.
- Fetch crossing `0xFFFFFFFC` → the next request is `imem_addr=0`; with `pc=0xFFFFFFFC`, `pc_plus4=0`.
- Redirect to `0x102`: with `FETCH_ALIGN_CHECK_EN` → `fetch_fault=1`, no further `imem_req`. Without it → the request goes to `0x100`.
